sd_avalon_stream_writer: RTL
============================

// Module: sd_avalon_stream_writer
// PURPOSE
//  Parametrised SD-to-memory loader back end. Accepts the raw byte stream from the SD card reader
//  and packs bytes into DATA_W words. Buffers packed words in a FIFO and writes each word through
//  the Avalon bridge (ack-terminated writes) into SDRAM, starting at BASE_ADDR.
//  Replaces the fixed 16-bit, unbuffered word-per-ack loader path; supports word count, timeout and status.
// PARAMETERS
//  DATA_W       16    word width; multiple of 8, 8..64; BPW = DATA_W/8 bytes per word
//  FIFO_DEPTH   8     packed-word FIFO entries; power of 2, >=2
//  ADDR_W       25    avalon byte-address width
//  CNT_W        24    word-count width
//  BASE_ADDR    0     byte address of the first word written
//  ACK_TIMEOUT  1024  max cycles avl_write may wait for avl_ack before error
// PORTS
//  clk50          in   1        system clock, all logic rising-edge
//  reset          in   1        synchronous, active-high; clears all state
//  start          in   1        1-cycle pulse; latches word_count, begins load (ignored unless IDLE/DONE/ERROR)
//  word_count     in   CNT_W    number of DATA_W words to load
//  sd_valid       in   1        byte available from SD reader
//  sd_data        in   8        byte from SD reader
//  sd_ready       out  1        byte accepted when sd_valid & sd_ready
//  avl_address    out  ADDR_W   byte address = BASE_ADDR + word_index*BPW
//  avl_byte_en    out  DATA_W/8 always all ones
//  avl_write      out  1        write request, held until avl_ack
//  avl_write_data out  DATA_W   FIFO head word
//  avl_ack        in   1        bridge acknowledge, completes current write
//  busy           out  1        high in STREAM/DRAIN
//  done           out  1        high in DONE until next start/reset
//  error          out  1        high in ERROR until next start/reset
//  words_written  out  CNT_W    count of acknowledged writes
// BEHAVIOUR
//  Reset values: sd_ready=0, avl_write=0, avl_address=BASE_ADDR, avl_write_data=0, busy=done=error=0,
//   words_written=0, FIFO empty, pack byte index=0, state IDLE. Reset mid-write drops avl_write next edge.
//  States: IDLE -start-> STREAM (word_count>0) or DONE (word_count==0, one cycle after start).
//   STREAM: sd_ready = !fifo_full & (words_packed < word_count). Bytes are packed LSB-first; byte k of a word
//    goes to bits [8k+7:8k]. On the BPW-th byte the word is pushed into the FIFO in the same cycle;
//    words_packed increments. When words_packed==word_count -> DRAIN; sd_ready=0, extra bytes are not accepted.
//   DRAIN: continue writes until FIFO empty and last ack seen -> DONE.
//   DONE/ERROR: sd_ready=0, avl_write=0; start re-enters load from BASE_ADDR, counters cleared.
//  Write side (STREAM and DRAIN): if !avl_write & FIFO non-empty, assert avl_write next cycle with head data
//   and current address; address/data/write stable until avl_ack sampled high. On ack: pop FIFO,
//   words_written+1, address += BPW, avl_write=0 for >=1 cycle (no back-to-back writes; prevents double write).
//   Address wraps modulo 2^ADDR_W.
//  FIFO: simultaneous push and pop in one cycle legal, occupancy unchanged. Full blocks sd_ready and never
//   drops a byte. Empty never asserts avl_write.
//  Timeout: a cycle counter counts while avl_write=1 & !avl_ack; reaching ACK_TIMEOUT -> ERROR, avl_write=0,
//   FIFO flushed. An ack on the same cycle as the timeout wins (write completes, no error).
//  Latency: first byte accepted to avl_write high = BPW + 1 cycles at full sd_valid rate.
// CONFIGURATION
//  SD_AVL_PROGRESS_HEX_EN defined: adds output hex_digits[19:0] = words_written[19:0] (5 nibbles, for the
//   HexDriver chain); updated on each ack, 0 at reset. Undefined: port absent, no extra logic.
// TESTING
//  DATA_W=16, word_count=3, bytes 01..06, ack 1 cycle after write -> writes 0x0201@0,0x0403@2,0x0605@4; done=1.
//  DATA_W=32, FIFO_DEPTH=2, ack withheld 50 cycles -> sd_ready low after 2 words packed; no byte lost; data in order.
//  word_count=0, start -> done=1 one cycle later; avl_write never asserted.
//  ACK_TIMEOUT=16, avl_ack never asserted -> error=1 16 cycles after avl_write rose; avl_write=0, busy=0.
//  reset asserted mid-write with FIFO holding 3 words -> next cycle avl_write=0, words_written=0; restart loads from BASE_ADDR.
//  10 extra bytes offered after last word -> sd_ready stays 0; words_written==word_count exactly.

Source files
------------

// File: rtl/sd_avalon_stream_writer.sv
// SD byte stream to SDRAM loader: packs bytes LSB-first into DATA_W words, buffers them, writes via Avalon.
// Optional macro SD_AVL_PROGRESS_HEX_EN adds hex_digits output mirroring words_written[19:0].
`timescale 1ns/1ps
module sd_avalon_stream_writer #(
    parameter int                DATA_W      = 16,
    parameter int                FIFO_DEPTH  = 8,
    parameter int                ADDR_W      = 25,
    parameter int                CNT_W       = 24,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                ACK_TIMEOUT = 1024
) (
    input  logic                  clk50,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_W-1:0]      word_count,
    input  logic                  sd_valid,
    input  logic [7:0]            sd_data,
    output logic                  sd_ready,
    output logic [ADDR_W-1:0]     avl_address,
    output logic [DATA_W/8-1:0]   avl_byte_en,
    output logic                  avl_write,
    output logic [DATA_W-1:0]     avl_write_data,
    input  logic                  avl_ack,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
`ifdef SD_AVL_PROGRESS_HEX_EN
    output logic [19:0]           hex_digits,
`endif
    output logic [CNT_W-1:0]      words_written
);

    localparam int BPW   = DATA_W / 8;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam int BI_W  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {ST_IDLE, ST_STREAM, ST_DRAIN, ST_DONE, ST_ERROR} state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]    occ_q;
    logic [DATA_W-1:0]   pack_q;
    logic [BI_W-1:0]     byte_idx_q;
    logic [CNT_W-1:0]    words_packed_q, word_count_q, words_written_q;
    logic                avl_write_q;
    logic [ADDR_W-1:0]   avl_address_q;
    logic [DATA_W-1:0]   avl_write_data_q;
    logic [TO_W-1:0]     to_cnt_q;

    logic [DATA_W-1:0]   pack_d;
    logic                last_byte, accept, push, pop, fifo_full, fifo_empty, timeout_hit;

    // The incoming byte is merged into the partial word so a completing byte can be pushed directly.
    always_comb begin
        pack_d = pack_q;
        for (int k = 0; k < BPW; k++) begin
            if (byte_idx_q == BI_W'(k)) pack_d[8*k +: 8] = sd_data;
        end
        last_byte   = (byte_idx_q == BI_W'(BPW - 1));
        accept      = sd_valid & sd_ready;
        push        = accept & last_byte;
        pop         = avl_write_q & avl_ack;
        fifo_full   = (occ_q == OCC_W'(FIFO_DEPTH));
        fifo_empty  = (occ_q == '0);
        timeout_hit = avl_write_q & ~avl_ack & (to_cnt_q == TO_W'(ACK_TIMEOUT - 1));
    end

    assign sd_ready       = (state_q == ST_STREAM) & ~fifo_full & (words_packed_q < word_count_q);
    assign avl_address    = avl_address_q;
    assign avl_byte_en    = '1;
    assign avl_write      = avl_write_q;
    assign avl_write_data = avl_write_data_q;
    assign busy           = (state_q == ST_STREAM) | (state_q == ST_DRAIN);
    assign done           = (state_q == ST_DONE);
    assign error          = (state_q == ST_ERROR);
    assign words_written  = words_written_q;
`ifdef SD_AVL_PROGRESS_HEX_EN
    assign hex_digits     = 20'(words_written_q);
`endif

    always_ff @(posedge clk50) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            occ_q            <= '0;
            pack_q           <= '0;
            byte_idx_q       <= '0;
            words_packed_q   <= '0;
            word_count_q     <= '0;
            words_written_q  <= '0;
            avl_write_q      <= 1'b0;
            avl_address_q    <= BASE_ADDR;
            avl_write_data_q <= '0;
            to_cnt_q         <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    avl_write_q <= 1'b0;
                    if (start) begin
                        word_count_q    <= word_count;
                        words_packed_q  <= '0;
                        words_written_q <= '0;
                        avl_address_q   <= BASE_ADDR;
                        byte_idx_q      <= '0;
                        pack_q          <= '0;
                        wr_ptr_q        <= '0;
                        rd_ptr_q        <= '0;
                        occ_q           <= '0;
                        to_cnt_q        <= '0;
                        state_q         <= (word_count == '0) ? ST_DONE : ST_STREAM;
                    end
                end
                ST_STREAM, ST_DRAIN: begin
                    if (accept) begin
                        if (last_byte) begin
                            mem_q[wr_ptr_q] <= pack_d;
                            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
                            words_packed_q  <= words_packed_q + CNT_W'(1);
                            byte_idx_q      <= '0;
                            pack_q          <= '0;
                        end else begin
                            pack_q     <= pack_d;
                            byte_idx_q <= byte_idx_q + BI_W'(1);
                        end
                    end
                    // Writes are never issued back to back: after each ack avl_write idles one cycle.
                    if (avl_write_q) begin
                        if (avl_ack) begin
                            avl_write_q     <= 1'b0;
                            rd_ptr_q        <= rd_ptr_q + PTR_W'(1);
                            words_written_q <= words_written_q + CNT_W'(1);
                            avl_address_q   <= avl_address_q + ADDR_W'(BPW);
                        end else begin
                            to_cnt_q <= to_cnt_q + TO_W'(1);
                        end
                    end else if (!fifo_empty) begin
                        avl_write_q      <= 1'b1;
                        avl_write_data_q <= mem_q[rd_ptr_q];
                        to_cnt_q         <= '0;
                    end
                    occ_q <= occ_q + OCC_W'(push) - OCC_W'(pop);
                    if (state_q == ST_STREAM && words_packed_q == word_count_q) state_q <= ST_DRAIN;
                    if (state_q == ST_DRAIN && fifo_empty && !avl_write_q) state_q <= ST_DONE;
                    // A stuck bridge aborts the load and discards everything still buffered.
                    if (timeout_hit) begin
                        state_q     <= ST_ERROR;
                        avl_write_q <= 1'b0;
                        occ_q       <= '0;
                        wr_ptr_q    <= '0;
                        rd_ptr_q    <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
